// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU control stage: function-select codes,
// branch-condition encodings, RV32I opcodes, immediate formats and the output payload.
package alu_pkg;

   localparam int unsigned ALU_W = 32;
   localparam int unsigned DNT_W = 4;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned DAL_W = 2;

   localparam logic [DNT_W-1:0] ALU_ADD = 4'b0000;
   localparam logic [DNT_W-1:0] ALU_SUB = 4'b0001;
   localparam logic [DNT_W-1:0] ALU_AND = 4'b0010;
   localparam logic [DNT_W-1:0] ALU_XOR = 4'b0011;
   localparam logic [DNT_W-1:0] ALU_SLT = 4'b0100;
   localparam logic [DNT_W-1:0] ALU_SGE = 4'b0101;
   localparam logic [DNT_W-1:0] ALU_GEU = 4'b0110;
   localparam logic [DNT_W-1:0] ALU_LTU = 4'b0111;
   localparam logic [DNT_W-1:0] ALU_LUI = 4'b1000;
   localparam logic [DNT_W-1:0] ALU_OR  = 4'b1010;
   localparam logic [DNT_W-1:0] ALU_SLL = 4'b1011;
   localparam logic [DNT_W-1:0] ALU_SRL = 4'b1100;
   localparam logic [DNT_W-1:0] ALU_SRA = 4'b1101;

   // Branch taken when the ALU's esit_mi equals 00 / 01, or always
   localparam logic [DAL_W-1:0] DAL_YOK      = 2'b00;
   localparam logic [DAL_W-1:0] DAL_KOSUL0   = 2'b01;
   localparam logic [DAL_W-1:0] DAL_KOSUL1   = 2'b10;
   localparam logic [DAL_W-1:0] DAL_KOSULSUZ = 2'b11;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      IMM_YOK,
      IMM_I,
      IMM_S,
      IMM_U,
      IMM_UL,
      IMM_J
   } imm_bicim_e;

   typedef enum logic {
      BOS  = 1'b0,
      DOLU = 1'b1
   } durum_e;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [DNT_W-1:0] alu_dnt;
      logic [RD_W-1:0]  rd;
      logic             yazma_en;
      logic             bellek_oku;
      logic             bellek_yaz;
      logic [DAL_W-1:0] dallanma;
      logic             gecersiz;
   } cikis_t;

   // IMM_UL keeps the LUI literal right-aligned; the ALU applies the <<12 itself
   function automatic logic [ALU_W-1:0] imm_uret(input imm_bicim_e bicim, input logic [31:7] k);
      logic [ALU_W-1:0] imm;
      case (bicim)
         IMM_I:   imm = {{20{k[31]}}, k[31:20]};
         IMM_S:   imm = {{20{k[31]}}, k[31:25], k[11:7]};
         IMM_U:   imm = {k[31:12], 12'b0};
         IMM_UL:  imm = {12'b0, k[31:12]};
         IMM_J:   imm = {{11{k[31]}}, k[31], k[19:12], k[20], k[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   function automatic logic [DNT_W-1:0] f3_dnt(input logic [2:0] f3, input logic alt);
      logic [DNT_W-1:0] kod;
      case (f3)
         3'b000:  kod = alt ? ALU_SUB : ALU_ADD;
         3'b001:  kod = ALU_SLL;
         3'b010:  kod = ALU_SLT;
         3'b011:  kod = ALU_LTU;
         3'b100:  kod = ALU_XOR;
         3'b101:  kod = alt ? ALU_SRA : ALU_SRL;
         3'b110:  kod = ALU_OR;
         default: kod = ALU_AND;
      endcase
      return kod;
   endfunction

endpackage

// File: rtl/buyruk_cozucu.sv
// Combinational RV32I decode: ALU operands, function select and
// writeback/memory/branch control for one instruction.
module buyruk_cozucu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] buyruk_i,
   input  logic [ALU_W-1:0] pc_i,
   input  logic [ALU_W-1:0] rs1_i,
   input  logic [ALU_W-1:0] rs2_i,
   output cikis_t           cozulen_c_o
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opcode = buyruk_i[6:0];
   assign f3     = buyruk_i[14:12];
   assign f7     = buyruk_i[31:25];

   cikis_t     c;
   imm_bicim_e bicim;
   logic       yaz;
   logic       hata;

   always_comb begin
      c     = '0;
      c.a   = rs1_i;
      c.b   = rs2_i;
      bicim = IMM_YOK;
      yaz   = 1'b0;
      hata  = 1'b0;

      case (opcode)
         OPC_OP: begin
            yaz       = 1'b1;
            c.alu_dnt = f3_dnt(f3, f7[5]);
            if (!((f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))))
               hata = 1'b1;
         end
         OPC_OPIMM: begin
            yaz       = 1'b1;
            bicim     = IMM_I;
            // Only the right shift uses bit 30 as a variant select
            c.alu_dnt = f3_dnt(f3, f7[5] && (f3 == 3'b101));
         end
         OPC_LUI: begin
            yaz       = 1'b1;
            bicim     = IMM_UL;
            c.a       = '0;
            c.alu_dnt = ALU_LUI;
         end
         OPC_AUIPC: begin
            yaz   = 1'b1;
            bicim = IMM_U;
            c.a   = pc_i;
         end
         OPC_LOAD: begin
            yaz          = 1'b1;
            bicim        = IMM_I;
            c.bellek_oku = 1'b1;
         end
         OPC_STORE: begin
            bicim        = IMM_S;
            c.bellek_yaz = 1'b1;
         end
         OPC_JAL: begin
            yaz        = 1'b1;
            bicim      = IMM_J;
            c.a        = pc_i;
            c.dallanma = DAL_KOSULSUZ;
         end
         OPC_JALR: begin
            yaz        = 1'b1;
            bicim      = IMM_I;
            c.dallanma = DAL_KOSULSUZ;
         end
         OPC_BRANCH: begin
            case (f3)
               3'b000:  begin c.alu_dnt = ALU_SUB; c.dallanma = DAL_KOSUL0; end
               3'b001:  begin c.alu_dnt = ALU_SUB; c.dallanma = DAL_KOSUL1; end
               3'b100:  begin c.alu_dnt = ALU_SLT; c.dallanma = DAL_KOSUL1; end
               3'b101:  begin c.alu_dnt = ALU_SGE; c.dallanma = DAL_KOSUL1; end
               3'b110:  begin c.alu_dnt = ALU_LTU; c.dallanma = DAL_KOSUL1; end
               3'b111:  begin c.alu_dnt = ALU_GEU; c.dallanma = DAL_KOSUL1; end
               default: hata = 1'b1;
            endcase
         end
         default: hata = 1'b1;
      endcase

      if (bicim != IMM_YOK)
         c.b = imm_uret(bicim, buyruk_i[31:7]);

      // Shift amount is 5 bits for both register and immediate forms
      if (c.alu_dnt inside {ALU_SLL, ALU_SRL, ALU_SRA})
         c.b = ALU_W'(c.b[4:0]);

      if (yaz) begin
         c.rd       = buyruk_i[11:7];
         c.yazma_en = (buyruk_i[11:7] != 5'd0);
      end

      if (hata) begin
         c          = '0;
         c.gecersiz = 1'b1;
      end
   end

   assign cozulen_c_o = c;

endmodule

// File: rtl/alu_denetim_birimi.sv
// Registered decode/issue stage in front of the ALU with valid/ready on both sides.
// Define ALU_SKID_EN for a one-entry skid buffer and a registered giris_hazir.
module alu_denetim_birimi
   import alu_pkg::*;
#(
   parameter int unsigned VERI_W     = 32,
   parameter int unsigned SIFIRLA_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              giris_gecerli,
   output logic              giris_hazir,
   input  logic [VERI_W-1:0] buyruk,
   input  logic [VERI_W-1:0] pc,
   input  logic [VERI_W-1:0] rs1_deger,
   input  logic [VERI_W-1:0] rs2_deger,
   input  logic              temizle,
   output logic              cikis_gecerli,
   input  logic              cikis_hazir,
   output logic [VERI_W-1:0] a,
   output logic [VERI_W-1:0] b,
   output logic [3:0]        alu_dnt,
   output logic [4:0]        rd,
   output logic              yazma_en,
   output logic              bellek_oku,
   output logic              bellek_yaz,
   output logic [1:0]        dallanma,
   output logic              gecersiz
);

   cikis_t cozulen;
   cikis_t cikis_q, cikis_d;
   durum_e durum_q, durum_d;
   logic   kabul;

   buyruk_cozucu u_cozucu (
      .buyruk_i    (buyruk),
      .pc_i        (pc),
      .rs1_i       (rs1_deger),
      .rs2_i       (rs2_deger),
      .cozulen_c_o (cozulen)
   );

`ifdef ALU_SKID_EN
   cikis_t skid_q, skid_d;
   logic   skid_dolu_q, skid_dolu_d;

   assign giris_hazir = !skid_dolu_q;
`else
   assign giris_hazir = (durum_q == BOS) || cikis_hazir;
`endif

   assign kabul = giris_gecerli && giris_hazir;

   // State and payload registers; rst outranks temizle
   always_ff @(posedge clk) begin
      if (rst) begin
         durum_q   <= BOS;
         cikis_q   <= '0;
         // Reserved parameter, fixed at 0, so a still resets to 0
         cikis_q.a <= ALU_W'(SIFIRLA_PC);
`ifdef ALU_SKID_EN
         skid_q      <= '0;
         skid_dolu_q <= 1'b0;
`endif
      end else begin
         durum_q <= durum_d;
         cikis_q <= cikis_d;
`ifdef ALU_SKID_EN
         skid_q      <= skid_d;
         skid_dolu_q <= skid_dolu_d;
`endif
      end
   end

   // Next state: flush drops everything including a same-cycle accept
   always_comb begin
      durum_d = durum_q;
      cikis_d = cikis_q;
`ifdef ALU_SKID_EN
      skid_d      = skid_q;
      skid_dolu_d = skid_dolu_q;
`endif
      if (temizle) begin
         durum_d = BOS;
`ifdef ALU_SKID_EN
         skid_dolu_d = 1'b0;
`endif
      end else begin
         case (durum_q)
            BOS: begin
               if (kabul) begin
                  cikis_d = cozulen;
                  durum_d = DOLU;
               end
            end
            DOLU: begin
               if (cikis_hazir) begin
`ifdef ALU_SKID_EN
                  if (skid_dolu_q) begin
                     cikis_d     = skid_q;
                     skid_dolu_d = 1'b0;
                  end else
`endif
                  if (kabul)
                     cikis_d = cozulen;
                  else
                     durum_d = BOS;
               end else begin
`ifdef ALU_SKID_EN
                  if (kabul) begin
                     skid_d      = cozulen;
                     skid_dolu_d = 1'b1;
                  end
`endif
               end
            end
            default: durum_d = BOS;
         endcase
      end
   end

   assign cikis_gecerli = (durum_q == DOLU);
   assign a             = cikis_q.a;
   assign b             = cikis_q.b;
   assign alu_dnt       = cikis_q.alu_dnt;
   assign rd            = cikis_q.rd;
   assign yazma_en      = cikis_q.yazma_en;
   assign bellek_oku    = cikis_q.bellek_oku;
   assign bellek_yaz    = cikis_q.bellek_yaz;
   assign dallanma      = cikis_q.dallanma;
   assign gecersiz      = cikis_q.gecersiz;

endmodule

// File: tb/tb_alu_denetim_birimi.sv
// Scoreboard bench for alu_denetim_birimi: directed RV32I cases, backpressure,
// flush and reset, then randomized instructions against a behavioural decoder.
module tb_alu_denetim_birimi;

   logic        clk = 1'b0;
   logic        rst;
   logic        giris_gecerli;
   logic        giris_hazir;
   logic [31:0] buyruk;
   logic [31:0] pc;
   logic [31:0] rs1_deger;
   logic [31:0] rs2_deger;
   logic        temizle;
   logic        cikis_gecerli;
   logic        cikis_hazir;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_dnt;
   logic [4:0]  rd;
   logic        yazma_en;
   logic        bellek_oku;
   logic        bellek_yaz;
   logic [1:0]  dallanma;
   logic        gecersiz;

   alu_denetim_birimi dut (
      .clk           (clk),
      .rst           (rst),
      .giris_gecerli (giris_gecerli),
      .giris_hazir   (giris_hazir),
      .buyruk        (buyruk),
      .pc            (pc),
      .rs1_deger     (rs1_deger),
      .rs2_deger     (rs2_deger),
      .temizle       (temizle),
      .cikis_gecerli (cikis_gecerli),
      .cikis_hazir   (cikis_hazir),
      .a             (a),
      .b             (b),
      .alu_dnt       (alu_dnt),
      .rd            (rd),
      .yazma_en      (yazma_en),
      .bellek_oku    (bellek_oku),
      .bellek_yaz    (bellek_yaz),
      .dallanma      (dallanma),
      .gecersiz      (gecersiz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  f;
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic        st;
      logic [1:0]  br;
      logic        ill;
      bit          chk_ab;
      bit          chk_rd;
   } bek_t;

   bek_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   bit   izle     = 1'b0;
   bit   rastgele = 1'b0;
   bit   stall_prev = 1'b0;
   logic [78:0] tutulan;

   function automatic logic [3:0] f3_kod(input logic [2:0] f3);
      case (f3)
         3'd0: return 4'd0;
         3'd1: return 4'd11;
         3'd2: return 4'd4;
         3'd3: return 4'd7;
         3'd4: return 4'd3;
         3'd5: return 4'd12;
         3'd6: return 4'd10;
         default: return 4'd2;
      endcase
   endfunction

   // Reference decoder, written from the instruction-set view
   function automatic bek_t model(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] r1, input logic [31:0] r2);
      bek_t        e;
      logic [6:0]  op = ins[6:0];
      logic [2:0]  f3 = ins[14:12];
      logic [6:0]  f7 = ins[31:25];
      logic [31:0] imm_i;
      logic [31:0] imm_s;
      logic [31:0] imm_j;
      logic [20:0] jraw;
      bit          yaz = 1'b0;
      imm_i = 32'($signed(ins) >>> 20);
      imm_s = 32'(($signed(ins) >>> 25) * 32) | 32'(ins[11:7]);
      jraw  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      imm_j = 32'($signed(jraw));
      e.a = r1; e.b = r2; e.f = 4'd0; e.rd = 5'd0; e.we = 1'b0; e.ld = 1'b0;
      e.st = 1'b0; e.br = 2'd0; e.ill = 1'b0; e.chk_ab = 1'b1; e.chk_rd = 1'b0;
      case (op)
         7'h33: begin
            yaz = 1'b1;
            if (f7 == 7'h00) e.f = f3_kod(f3);
            else if (f7 == 7'h20 && f3 == 3'd0) e.f = 4'd1;
            else if (f7 == 7'h20 && f3 == 3'd5) e.f = 4'd13;
            else e.ill = 1'b1;
            if (f3 == 3'd1 || f3 == 3'd5) e.b = r2 % 32;
         end
         7'h13: begin
            yaz = 1'b1;
            e.f = (f3 == 3'd5 && ins[30]) ? 4'd13 : f3_kod(f3);
            e.b = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : imm_i;
         end
         7'h37: begin yaz = 1'b1; e.f = 4'd8; e.a = 32'd0; e.b = ins >> 12; end
         7'h17: begin yaz = 1'b1; e.a = p; e.b = ins & 32'hFFFF_F000; end
         7'h03: begin yaz = 1'b1; e.b = imm_i; e.ld = 1'b1; end
         7'h23: begin e.b = imm_s; e.st = 1'b1; end
         7'h6F: begin yaz = 1'b1; e.a = p; e.b = imm_j; e.br = 2'd3; end
         7'h67: begin yaz = 1'b1; e.b = imm_i; e.br = 2'd3; end
         7'h63: begin
            case (f3)
               3'd0: begin e.f = 4'd1; e.br = 2'd1; end
               3'd1: begin e.f = 4'd1; e.br = 2'd2; end
               3'd4: begin e.f = 4'd4; e.br = 2'd2; end
               3'd5: begin e.f = 4'd5; e.br = 2'd2; end
               3'd6: begin e.f = 4'd7; e.br = 2'd2; end
               3'd7: begin e.f = 4'd6; e.br = 2'd2; end
               default: e.ill = 1'b1;
            endcase
         end
         default: e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.f = 4'd0; e.br = 2'd0; e.ld = 1'b0; e.st = 1'b0; e.we = 1'b0;
         e.chk_ab = 1'b0; e.chk_rd = 1'b0;
      end else if (yaz) begin
         e.chk_rd = 1'b1;
         e.rd     = ins[11:7];
         e.we     = (ins[11:7] != 5'd0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rastgele_buyruk();
      int          s = $urandom_range(0, 10);
      logic [31:0] w = $urandom;
      case (s)
         0: begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 3))
               0, 1: w[31:25] = 7'h00;
               2: w[31:25] = 7'h20;
               default: ;
            endcase
         end
         1: begin
            w[6:0] = 7'h13;
            if (w[14:12] == 3'd1) w[31:25] = 7'h00;
            if (w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         2: w[6:0] = 7'h37;
         3: w[6:0] = 7'h17;
         4: w[6:0] = 7'h03;
         5: w[6:0] = 7'h23;
         6: w[6:0] = 7'h6F;
         7: w[6:0] = 7'h67;
         8, 9: w[6:0] = 7'h63;
         default: ;
      endcase
      return w;
   endfunction

   task automatic kontrol(input string ad, input logic [79:0] gercek, input logic [79:0] beklenen);
      checks++;
      if (gercek !== beklenen) begin
         failures++;
         $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
      end
   endtask

   // Driver: hold the word until the handshake completes, then push its expectation
   task automatic gonder(input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2);
      bit alindi = 1'b0;
      giris_gecerli = 1'b1;
      buyruk = ins; pc = p; rs1_deger = r1; rs2_deger = r2;
      for (int i = 0; i < 200 && !alindi; i++) begin
         @(negedge clk); #1;
         if (giris_hazir) begin
            alindi = 1'b1;
            if (!temizle && !rst) sb.push_back(model(ins, p, r1, r2));
         end
         @(posedge clk); #1;
      end
      giris_gecerli = 1'b0;
      if (!alindi) begin
         checks++; failures++;
         $display("FAIL giris_zaman_asimi: buyruk %h never accepted within 200 cycles", ins);
      end
   endtask

   // Consumer backpressure when random mode is on
   always begin
      @(posedge clk); #1;
      if (rastgele) cikis_hazir = ($urandom_range(0, 3) != 0);
   end

   // Monitor: occupancy, ready, hold stability, and in-order payload checks
   always @(negedge clk) begin
      if (izle) begin
         bek_t        e;
         logic [78:0] simdi;
         bit          bos;
         simdi = {a, b, alu_dnt, rd, yazma_en, bellek_oku, bellek_yaz, dallanma, gecersiz};
         kontrol("cikis_gecerli_doluluk", 80'(cikis_gecerli), 80'(sb.size() > 0));
`ifdef ALU_SKID_EN
         kontrol("giris_hazir", 80'(giris_hazir), 80'(sb.size() < 2));
`else
         kontrol("giris_hazir", 80'(giris_hazir), 80'((sb.size() == 0) || cikis_hazir));
`endif
         if (stall_prev) begin
            kontrol("bekleme_sabit", 80'(simdi), 80'(tutulan));
            kontrol("bekleme_gecerli", 80'(cikis_gecerli), 80'(1));
         end
         stall_prev = cikis_gecerli && !cikis_hazir && !temizle && !rst;
         tutulan    = simdi;
         if (rst || temizle) begin
            sb.delete();
         end else if (cikis_gecerli && cikis_hazir && sb.size() > 0) begin
            e = sb.pop_front();
            bos = (alu_dnt !== e.f) || (yazma_en !== e.we) || (bellek_oku !== e.ld) ||
                  (bellek_yaz !== e.st) || (dallanma !== e.br) || (gecersiz !== e.ill) ||
                  (e.chk_ab && ((a !== e.a) || (b !== e.b))) || (e.chk_rd && (rd !== e.rd));
            checks++;
            if (bos) begin
               failures++;
               $display("FAIL cikis_yuku: got a=%h b=%h dnt=%b rd=%0d we=%b ld=%b st=%b br=%b ill=%b expected a=%h b=%h dnt=%b rd=%0d we=%b ld=%b st=%b br=%b ill=%b",
                        a, b, alu_dnt, rd, yazma_en, bellek_oku, bellek_yaz, dallanma, gecersiz,
                        e.a, e.b, e.f, e.rd, e.we, e.ld, e.st, e.br, e.ill);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bitti;
      rst = 1'b1; giris_gecerli = 1'b0; buyruk = '0; pc = '0;
      rs1_deger = '0; rs2_deger = '0; temizle = 1'b0; cikis_hazir = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      kontrol("reset_cikislar", {a, b, alu_dnt, rd, yazma_en, bellek_oku, bellek_yaz, dallanma, gecersiz, cikis_gecerli}, 80'd0);
      kontrol("reset_giris_hazir", 80'(giris_hazir), 80'(1));
      izle = 1'b1;
      @(posedge clk); #1;

      // Directed decode cases
      gonder(32'h002081B3, 32'h0000_1000, 32'd5, 32'd7);
      gonder(32'h40335293, 32'h0000_1004, 32'h8000_0000, 32'd0);
      gonder(32'h002092B3, 32'h0000_1008, 32'd1, 32'h0000_0025);
      gonder(32'h123450B7, 32'h0000_100C, 32'hDEAD_BEEF, 32'h1234_5678);
      gonder(32'h12345037, 32'h0000_1010, 32'd0, 32'd0);
      gonder(32'h0020E063, 32'h0000_1014, 32'd3, 32'd9);
      gonder(32'h00208063, 32'h0000_1018, 32'd3, 32'd3);
      gonder(32'hFFFF_FFFF, 32'h0000_101C, 32'd1, 32'd2);
      gonder(32'h0020A063, 32'h0000_1020, 32'd1, 32'd2);

      // Backpressure: two queued inputs while the consumer stalls
      cikis_hazir = 1'b0;
      bitti = 1'b0;
      fork
         begin
            gonder(32'h00A00093, 32'h0000_2000, 32'd11, 32'd12);
            gonder(32'h40208133, 32'h0000_2004, 32'd20, 32'd6);
            bitti = 1'b1;
         end
      join_none
      repeat (6) @(posedge clk);
      #1 cikis_hazir = 1'b1;
      for (int i = 0; i < 400 && !bitti; i++) @(posedge clk);
      if (!bitti) kontrol("geri_basinc_bitis", 80'(0), 80'(1));
      repeat (3) @(posedge clk); #1;

      // Flush with a concurrent accept
      gonder(32'h00308193, 32'h0000_3000, 32'd1, 32'd1);
      temizle = 1'b1;
      gonder(32'h00408213, 32'h0000_3004, 32'd2, 32'd2);
      temizle = 1'b0;
      @(negedge clk);
      kontrol("temizle_gecerli", 80'(cikis_gecerli), 80'(0));
      @(posedge clk); #1;

      // Reset in the middle of a stall
      cikis_hazir = 1'b0;
      gonder(32'hFFF28293, 32'h0000_4000, 32'h55AA_55AA, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      kontrol("stall_reset_cikislar", {a, b, alu_dnt, rd, yazma_en, bellek_oku, bellek_yaz, dallanma, gecersiz, cikis_gecerli}, 80'd0);
      @(posedge clk); #1;
      cikis_hazir = 1'b1;

      // Randomized traffic with random backpressure and occasional flush
      rastgele = 1'b1;
      for (int n = 0; n < 300; n++) begin
         temizle = ($urandom_range(0, 29) == 0);
         gonder(rastgele_buyruk(), $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
         temizle = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
      end
      rastgele = 1'b0;
      cikis_hazir = 1'b1;
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      kontrol("bosaltma", 80'(sb.size()), 80'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
